atanh_cordic_vectoring: RTL and testbench

Sequential hyperbolic CORDIC engine in vectoring mode. It sits directly downstream of the float32 divider and consumes its quotient r, a float32 with |r| < 1. It converts r to signed fixed point and iterates to produce z = atanh(r). A valid/ready handshake sits on both sides.

---
 rtl/atanh_cordic_vectoring.sv | 189 ++++++++++++++++++
 tb/tb_atanh_cordic_vectoring.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/atanh_cordic_vectoring.sv
// Sequential hyperbolic CORDIC in vectoring mode: converts a float32 quotient |r| < 1 to
// fixed point and iterates one micro-rotation per cycle to produce z = atanh(r).
module atanh_cordic_vectoring #(
  parameter int unsigned ITER  = 16,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned FRAC  = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  localparam int unsigned NSTEP = ITER + ((ITER >= 4) ? 1 : 0) + ((ITER >= 13) ? 1 : 0);
  localparam int unsigned SW    = $clog2(NSTEP + 1);
  localparam int unsigned IW    = ($clog2(ITER + 2) > 4) ? $clog2(ITER + 2) : 4;

  localparam logic [SW-1:0]    LastStep = SW'(NSTEP - 1);
  localparam logic [WIDTH-1:0] XInit    = WIDTH'(1) << FRAC;

  typedef enum logic [1:0] {StIdle, StConv, StIter, StDone} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              data_q, data_d;
  logic signed [WIDTH-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
  logic [SW-1:0]            step_q, step_d;
  logic [IW-1:0]            idx_q, idx_d;
  logic                     rep_q, rep_d;
  logic [WIDTH-1:0]         out_data_q, out_data_d;
  logic                     out_err_q, out_err_d;

  // Table is held in Q.30 and rescaled to FRAC; beyond i=10 atanh(2^-i) rounds to 2^-i.
  function automatic logic [WIDTH-1:0] atanh_tab(input int i);
    logic [63:0]      q30;
    logic [WIDTH-1:0] res;
    case (i)
      1:       q30 = 64'd589812981;
      2:       q30 = 64'd274247419;
      3:       q30 = 64'd134923406;
      4:       q30 = 64'd67196451;
      5:       q30 = 64'd33565361;
      6:       q30 = 64'd16778582;
      7:       q30 = 64'd8388779;
      8:       q30 = 64'd4194325;
      9:       q30 = 64'd2097155;
      10:      q30 = 64'd1048576;
      default: q30 = (i >= 11 && i <= 30) ? (64'd1 << (30 - i)) : 64'd0;
    endcase
    if (FRAC >= 30) res = WIDTH'(q30 << (FRAC - 30));
    else            res = WIDTH'((q30 + (64'd1 << (29 - FRAC))) >> (30 - FRAC));
    return res;
  endfunction

  // Float decode of the captured operand
  logic                    f_sign;
  logic [7:0]              f_exp;
  logic [22:0]             f_man;
  logic                    conv_err;
  logic [63:0]             scaled;
  logic [7:0]              rsh;
  logic [WIDTH-1:0]        mag;
  logic signed [WIDTH-1:0] r_fixed;

  always_comb begin
    f_sign   = data_q[31];
    f_exp    = data_q[30:23];
    f_man    = data_q[22:0];
    conv_err = (f_exp >= 8'd127);
    if (FRAC >= 23) scaled = {40'd0, 1'b1, f_man} << (FRAC - 23);
    else            scaled = {40'd0, 1'b1, f_man} >> (23 - FRAC);
    rsh = 8'd127 - f_exp;
    if (f_exp == 8'd0 || 32'(rsh) >= WIDTH) mag = '0;
    else                                    mag = WIDTH'(scaled >> rsh);
    r_fixed = f_sign ? -$signed(mag) : $signed(mag);
  end

  // One micro-rotation at the current shift index
  logic signed [WIDTH-1:0] x_sh, y_sh, t_val, x_rot, y_rot, z_rot;

  always_comb begin
    x_sh  = x_q >>> idx_q;
    y_sh  = y_q >>> idx_q;
    t_val = $signed(atanh_tab(int'(idx_q)));
    if (!y_q[WIDTH-1]) begin
      x_rot = x_q - y_sh;
      y_rot = y_q - x_sh;
      z_rot = z_q + t_val;
    end else begin
      x_rot = x_q + y_sh;
      y_rot = y_q + x_sh;
      z_rot = z_q - t_val;
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    x_d        = x_q;
    y_d        = y_q;
    z_d        = z_q;
    step_d     = step_q;
    idx_d      = idx_q;
    rep_d      = rep_q;
    out_data_d = out_data_q;
    out_err_d  = out_err_q;
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          data_d  = in_data;
          state_d = StConv;
        end
      end
      StConv: begin
        if (conv_err) begin
          out_data_d = '0;
          out_err_d  = 1'b1;
          state_d    = StDone;
        end else begin
          x_d     = XInit;
          y_d     = r_fixed;
          z_d     = '0;
          step_d  = '0;
          idx_d   = IW'(1);
          rep_d   = 1'b0;
          state_d = StIter;
        end
      end
      StIter: begin
        x_d    = x_rot;
        y_d    = y_rot;
        z_d    = z_rot;
        step_d = step_q + SW'(1);
        // Indices 4 and 13 run twice so the hyperbolic sequence converges
        if ((idx_q == IW'(4) || idx_q == IW'(13)) && !rep_q) begin
          rep_d = 1'b1;
        end else begin
          idx_d = idx_q + IW'(1);
          rep_d = 1'b0;
        end
        if (step_q == LastStep) begin
          out_data_d = z_rot;
          out_err_d  = 1'b0;
          state_d    = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      data_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      z_q        <= '0;
      step_q     <= '0;
      idx_q      <= '0;
      rep_q      <= 1'b0;
      out_data_q <= '0;
      out_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      x_q        <= x_d;
      y_q        <= y_d;
      z_q        <= z_d;
      step_q     <= step_d;
      idx_q      <= idx_d;
      rep_q      <= rep_d;
      out_data_q <= out_data_d;
      out_err_q  <= out_err_d;
    end
  end

  assign in_ready  = (state_q == StIdle) && !rst;
  assign out_valid = (state_q == StDone);
  assign out_data  = out_data_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_atanh_cordic_vectoring.sv
// Scoreboard bench for atanh_cordic_vectoring: directed operands with hand-computed atanh values,
// error inputs, output backpressure and a mid-operation reset.
module tb_atanh_cordic_vectoring;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        in_data;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_data;
  logic               out_err;

  atanh_cordic_vectoring #(.ITER(16), .WIDTH(32), .FRAC(30)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  typedef struct {
    longint data;
    logic   err;
    longint tol;
    int     lat;
    int     acc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  localparam longint Tol = 65536;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

  task automatic check(input string name, input bit ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  // Monitor: latency on rise, stability under backpressure, value on transfer
  logic   prev_valid = 1'b0;
  longint held_data;
  logic   held_err;
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && !prev_valid) begin
        if (q.size() == 0) begin
          check("unexpected_valid", 1'b0, 1, 0);
        end else begin
          check("latency", (cyc - q[0].acc) == q[0].lat, cyc - q[0].acc, q[0].lat);
        end
        held_data = out_data;
        held_err  = out_err;
      end else if (out_valid) begin
        check("hold_data", out_data == held_data, out_data, held_data);
        check("hold_err", out_err == held_err, out_err, held_err);
      end
      if (out_valid && out_ready && q.size() > 0) begin
        exp_t e;
        longint diff;
        e = q.pop_front();
        check("out_err", out_err == e.err, out_err, e.err);
        diff = longint'(out_data) - e.data;
        if (e.err) check("err_data", out_data == 0, out_data, 0);
        else       check("out_data", diff <= e.tol && diff >= -e.tol, out_data, e.data);
      end
    end
    prev_valid = out_valid;
  end

  task automatic send(input logic [31:0] d, input longint exp_v, input logic err, input int lat,
                      input bit track);
    bit got;
    got = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        if (track) q.push_back('{data: exp_v, err: err, tol: Tol, lat: lat, acc: cyc + 1});
      end
    end
    if (!got) check("accept_timeout", 1'b0, 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (q.size() == 0 && !out_valid) done = 1'b1;
    end
    if (!done) check("drain_timeout", 1'b0, q.size(), 0);
  endtask

  initial begin
    bit seen;
    int xfer_edge;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready == 1'b0, in_ready, 0);
    check("rst_out_valid", out_valid == 1'b0, out_valid, 0);
    check("rst_out_data", out_data == 0, out_data, 0);
    check("rst_out_err", out_err == 1'b0, out_err, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", in_ready == 1'b1, in_ready, 1);

    send(32'h3F000000,  589812982, 1'b0, 19, 1'b1);
    send(32'hBF000000, -589812982, 1'b0, 19, 1'b1);
    send(32'h3E800000,  274247418, 1'b0, 19, 1'b1);
    send(32'hBE800000, -274247418, 1'b0, 19, 1'b1);
    send(32'h00000000,  0,         1'b0, 19, 1'b1);
    send(32'h00000001,  0,         1'b0, 19, 1'b1);
    send(32'h3F800000,  0,         1'b1, 1,  1'b1);
    send(32'hC0000000,  0,         1'b1, 1,  1'b1);
    send(32'h7FC00000,  0,         1'b1, 1,  1'b1);
    send(32'h7F800000,  0,         1'b1, 1,  1'b1);
    wait_drain();

    // Backpressure with a new operand waiting upstream
    out_ready = 1'b0;
    send(32'h3F000000, 589812982, 1'b0, 19, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("bp_valid_seen", seen, seen, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_data  = 32'h3E800000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_in_ready", in_ready == 1'b0, in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    xfer_edge = cyc + 1;
    check("xfer_in_ready", in_ready == 1'b0, in_ready, 0);
    @(negedge clk);
    check("post_xfer_ready", in_ready == 1'b1, in_ready, 1);
    if (in_ready) begin
      check("accept_edge", (cyc + 1) == xfer_edge + 1, cyc + 1, xfer_edge + 1);
      q.push_back('{data: 274247418, err: 1'b0, tol: Tol, lat: 19, acc: cyc + 1});
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    wait_drain();

    // Reset during the seventh micro-rotation
    send(32'h3F000000, 0, 1'b0, 19, 1'b0);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", in_ready == 1'b0, in_ready, 0);
    check("midrst_out_valid", out_valid == 1'b0, out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_ready_after", in_ready == 1'b1, in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_valid", seen == 1'b0, seen, 0);
    send(32'h3E800000, 274247418, 1'b0, 19, 1'b1);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
